func_inst_sched: RTL
====================

# func_inst_sched

Per-function call scheduler. Shares `INST_NUM` hardware instances of one accelerated function between `REQ_NUM` caller ports.
- Round-robin arbitration across callers.
- Dispatches each accepted call to the lowest-index idle instance.
- Records which caller owns each instance.
- Routes each instance's return value back to the owning caller through a per-caller response holding register.

Sits between the caller-side command path and the function instances of one L1 group.

## Interface
Parameters:
- `REQ_NUM`, 4, number of caller ports (2..16)
- `INST_NUM`, 2, number of function instances (1..8)
- `ARG_NUM`, 8, arguments per call
- `ARG_W`, 32, bits per argument
- `RET_DW`, 32, return value width

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rstn` in 1: reset, asynchronous, active-low
- `req_valid` in `REQ_NUM`: caller r has a call pending
- `req_ready` out `REQ_NUM`: call from caller r accepted this cycle; combinational, one-hot or zero
- `req_args` in `REQ_NUM`×`ARG_NUM`×`ARG_W`: call arguments per caller
- `inst_start` out `INST_NUM`: one-cycle start pulse per instance
- `inst_args` out `INST_NUM`×`ARG_NUM`×`ARG_W`: registered arguments; held from start until the next start of that instance
- `inst_done` in `INST_NUM`: one-cycle completion pulse per instance
- `inst_ret` in `INST_NUM`×`RET_DW`: return value, valid with `inst_done`
- `rsp_valid` out `REQ_NUM`: return value available for caller r
- `rsp_ready` in `REQ_NUM`: caller r consumes the response
- `rsp_data` out `REQ_NUM`×`RET_DW`: return value per caller
- `inst_busy` out `INST_NUM`: instance currently owned
- `err_unexp_done` out 1: sticky; set when `inst_done` arrives for an instance that is not busy

## Operation
- Caller state: `pend[r]` is set on request handshake and cleared on response handshake. At most one outstanding call per caller.
- Eligibility: caller r is eligible when `req_valid[r] && !pend[r]`.
- Grant condition: at least one instance is idle (`!inst_busy`) and at least one caller is eligible.
- Arbitration: round-robin from pointer `rr_ptr`. At most one grant per cycle.
- On grant:
  - `rr_ptr <= granted+1`, wrapping modulo `REQ_NUM`.
  - The chosen instance is the lowest-index idle one.
  - `owner[i] <= granted`, `inst_busy[i] <= 1`, `inst_args[i] <= req_args[granted]`.
- Completion: on `inst_done[i]` with `inst_busy[i]`:
  - `rsp_data[owner[i]] <= inst_ret[i]`, `rsp_valid[owner[i]] <= 1`.
  - `inst_busy[i] <= 0`.
- Owners are distinct callers, so simultaneous `inst_done` on several instances write different response registers with no conflict.
- Response handshake: `rsp_valid[r] && rsp_ready[r]` clears `rsp_valid[r]` and `pend[r]`.
- Unexpected done: `inst_done[i]` with `!inst_busy[i]` is dropped and sets `err_unexp_done`, which clears only on reset.
- Owner width: `owner` is `$clog2(REQ_NUM)` bits, minimum 1.

## Timing
- Reset values:
  - `req_ready`, `inst_start`, `inst_busy`, `rsp_valid`, `err_unexp_done` are 0.
  - `rsp_data`, `inst_args` are 0.
  - `rr_ptr` is 0; `pend` is 0.
- `req_ready[r]` depends on `req_valid`, `pend`, `inst_busy`, `rr_ptr`. It never depends on `inst_done` in the same cycle.
- Call latency:
  - Request handshake in cycle T gives `inst_start[i]` at T+1, with `inst_args[i]` valid at T+1.
  - `inst_busy[i]` is 1 from T+1.
- Return latency: `inst_done[i]` in cycle D gives `rsp_valid[owner]` at D+1. `inst_busy[i]` is 0 at D+1, so the instance can be granted in cycle D+1 and starts at D+2.
- Instance contract: `inst_done` never arrives in the start cycle; minimum instance latency is 1 cycle.
- Back-to-back responses: a caller with `rsp_ready` held at 1 consumes in cycle D+1. It becomes eligible again in cycle D+2.
- All instances busy: `req_ready` stays all 0 and `rr_ptr` holds.
- Reset mid-operation: all ownership and responses are discarded. A late `inst_done` from a previously started instance sets `err_unexp_done`.

## Structure
- Add to the shared function-arbiter package:
  - `arg_vec_t` (`ARG_NUM`×`ARG_W` packed)
  - `ret_t` (`RET_DW`)
  - function `first_idle_idx` (lowest set bit of an `INST_NUM` vector)
- One sub-module, `func_rr_arb`:
  - Parameter `N`.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register lives in `func_inst_sched`.

## Test plan
- Single call: caller 2 requests with args {1..8}, instance returns 0xCAFE after 3 cycles.
  - `inst_start[0]` at T+1, `inst_args[0]` = {1..8}.
  - `rsp_valid[2]` at T+5, `rsp_data[2]` = 0xCAFE.
- Fairness: `REQ_NUM`=4, all callers valid continuously, instances return after 1 cycle.
  - Grant order is 0,1,2,3,0,…
  - No caller is granted twice before all other eligible callers are served.
- Saturation: 4 callers, `INST_NUM`=2, long latency.
  - Only 2 grants occur; `req_ready` stays 0 until a `inst_done`.
  - The freed instance is regranted in the cycle after done.
- Simultaneous done: instances 0 and 1, owned by callers 3 and 1, finish in the same cycle.
  - Both `rsp_valid[3]` and `rsp_valid[1]` rise next cycle with the correct values.
- Response backpressure: hold `rsp_ready[1]`=0 for 10 cycles.
  - Caller 1 is never regranted while `rsp_valid[1]`=1.
  - The instance is freed and serves another caller meanwhile.
- Error and reset: pulse `inst_done[1]` with the instance idle, gives `err_unexp_done`=1. Then assert `rstn` low mid-call, and all outputs return to their reset values.

Source files
------------

// File: rtl/func_inst_sched_pkg.sv
// func_inst_sched_pkg: shared types, defaults and helpers for the function-call arbiter
package func_inst_sched_pkg;
   localparam int DEF_ARG_NUM = 8;
   localparam int DEF_ARG_W   = 32;
   localparam int DEF_RET_DW  = 32;
   localparam int INST_MAX    = 8;
   typedef logic [DEF_ARG_NUM-1:0][DEF_ARG_W-1:0] arg_vec_t;
   typedef logic [DEF_RET_DW-1:0] ret_t;
   function automatic logic [2:0] first_idle_idx(input logic [INST_MAX-1:0] idle);
      first_idle_idx = '0;
      for (int i = INST_MAX - 1; i >= 0; i--)
         if (idle[i]) first_idle_idx = 3'(i);
   endfunction
endpackage

// File: rtl/func_rr_arb.sv
// func_rr_arb: combinational round-robin arbiter, search starts at ptr_i
module func_rr_arb #(
   parameter int N = 4,
   parameter int W = N > 1 ? $clog2(N) : 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o
);
   // scan from the farthest slot back toward ptr_i so the nearest requester wins
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_i) + k) % N]) begin
            gnt_o = N'(1) << ((int'(ptr_i) + k) % N);
            idx_o = W'((int'(ptr_i) + k) % N);
         end
      end
   end
endmodule

// File: rtl/func_inst_sched.sv
// func_inst_sched: shares INST_NUM function instances among REQ_NUM callers with round-robin grants
module func_inst_sched
   import func_inst_sched_pkg::*;
#(
   parameter int REQ_NUM  = 4,
   parameter int INST_NUM = 2,
   parameter int ARG_NUM  = DEF_ARG_NUM,
   parameter int ARG_W    = DEF_ARG_W,
   parameter int RET_DW   = DEF_RET_DW
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic [REQ_NUM-1:0]                    req_valid,
   output logic [REQ_NUM-1:0]                    req_ready,
   input  logic [REQ_NUM*ARG_NUM*ARG_W-1:0]      req_args,
   output logic [INST_NUM-1:0]                   inst_start,
   output logic [INST_NUM*ARG_NUM*ARG_W-1:0]     inst_args,
   input  logic [INST_NUM-1:0]                   inst_done,
   input  logic [INST_NUM*RET_DW-1:0]            inst_ret,
   output logic [REQ_NUM-1:0]                    rsp_valid,
   input  logic [REQ_NUM-1:0]                    rsp_ready,
   output logic [REQ_NUM*RET_DW-1:0]             rsp_data,
   output logic [INST_NUM-1:0]                   inst_busy,
   output logic                                  err_unexp_done
);
   localparam int AW = ARG_NUM * ARG_W;
   localparam int PW = REQ_NUM > 1 ? $clog2(REQ_NUM) : 1;
   localparam int IW = INST_NUM > 1 ? $clog2(INST_NUM) : 1;

   logic [REQ_NUM-1:0]                 pend_q, rsp_valid_q, arb_req;
   logic [PW-1:0]                      rr_q, gnt_idx;
   logic [INST_NUM-1:0]                busy_q, start_q;
   logic [INST_NUM-1:0][PW-1:0]        owner_q;
   logic [INST_NUM*AW-1:0]             args_q;
   logic [REQ_NUM*RET_DW-1:0]          rsp_data_q;
   logic                               err_q;
   logic [IW-1:0]                      idle_idx;

   // callers compete only while some instance is free; nothing is granted in reset
   assign arb_req  = (rstn && !(&busy_q)) ? (req_valid & ~pend_q) : '0;
   assign idle_idx = IW'(first_idle_idx(INST_MAX'(~busy_q)));

   func_rr_arb #(.N(REQ_NUM), .W(PW)) u_arb (
      .req_i (arb_req),
      .ptr_i (rr_q),
      .gnt_o (req_ready),
      .idx_o (gnt_idx)
   );

   // dispatch, completion routing and response handshake; the paths touch disjoint bits
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_q      <= '0;
         rsp_valid_q <= '0;
         rr_q        <= '0;
         busy_q      <= '0;
         start_q     <= '0;
         owner_q     <= '0;
         args_q      <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         start_q <= '0;
         if (|req_ready) begin
            rr_q                          <= (gnt_idx == PW'(REQ_NUM - 1)) ? '0 : gnt_idx + 1'b1;
            pend_q[gnt_idx]               <= 1'b1;
            start_q[idle_idx]             <= 1'b1;
            busy_q[idle_idx]              <= 1'b1;
            owner_q[idle_idx]             <= gnt_idx;
            args_q[idle_idx*AW +: AW]     <= req_args[gnt_idx*AW +: AW];
         end
         for (int i = 0; i < INST_NUM; i++) begin
            if (inst_done[i] && busy_q[i]) begin
               rsp_data_q[owner_q[i]*RET_DW +: RET_DW] <= inst_ret[i*RET_DW +: RET_DW];
               rsp_valid_q[owner_q[i]]                 <= 1'b1;
               busy_q[i]                               <= 1'b0;
            end else if (inst_done[i]) begin
               err_q <= 1'b1;
            end
         end
         for (int r = 0; r < REQ_NUM; r++) begin
            if (rsp_valid_q[r] && rsp_ready[r]) begin
               rsp_valid_q[r] <= 1'b0;
               pend_q[r]      <= 1'b0;
            end
         end
      end
   end

   assign inst_start     = start_q;
   assign inst_args      = args_q;
   assign inst_busy      = busy_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign err_unexp_done = err_q;
endmodule
